// File: rtl/spike_event_logger.sv
// Event logger for a two-neuron spiking core: timestamps spike events and queues
// them in a first-word-fall-through FIFO with overflow accounting.
module spike_event_logger #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned TSW   = 10
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ena,
  input  logic                         spike_n1,
  input  logic                         spike_n2,
  input  logic [5:0]                   weight,
  input  logic                         clear,
  input  logic                         rd_en,
  output logic [TSW+7:0]               rd_data,
  output logic                         rd_valid,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         full,
  output logic [7:0]                   drop_count,
  output logic                         overflow
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned EW = TSW + 8;

  logic [EW-1:0]  mem_q [DEPTH];
  logic [AW-1:0]  wptr_q, wptr_d;
  logic [AW-1:0]  rptr_q, rptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [TSW-1:0] ts_q, ts_d;
  logic [7:0]     drop_q, drop_d;
  logic           ovf_q, ovf_d;

  logic           event_in;
  logic           is_full;
  logic           is_empty;
  logic           pop;
  logic           push;
  logic           wr_en;
  logic [EW-1:0]  entry;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign is_full  = (count_q == CW'(DEPTH));
  assign is_empty = (count_q == '0);
  assign event_in = ena & (spike_n1 | spike_n2);
  assign pop      = rd_en & ~is_empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push     = event_in & (~is_full | pop);
  assign wr_en    = push & ~clear;
  assign entry    = {spike_n1, spike_n2, ts_q, weight};

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ts_d    = ts_q;
    drop_d  = drop_q;
    ovf_d   = ovf_q;

    if (clear) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      ts_d    = '0;
      drop_d  = '0;
      ovf_d   = 1'b0;
    end else begin
      if (ena) ts_d = ts_q + 1'b1;
      if (push) wptr_d = ptr_inc(wptr_q);
      if (pop) rptr_d = ptr_inc(rptr_q);
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      if (event_in && !push) begin
        ovf_d = 1'b1;
        if (drop_q != 8'hFF) drop_d = drop_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ts_q    <= '0;
      drop_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ts_q    <= ts_d;
      drop_q  <= drop_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (wr_en && rst_n) mem_q[wptr_q] <= entry;
  end

  assign rd_valid   = ~is_empty;
  assign rd_data    = is_empty ? '0 : mem_q[rptr_q];
  assign level      = count_q;
  assign full       = is_full;
  assign drop_count = drop_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_spike_event_logger.sv
// Directed bench for spike_event_logger: a queue-based model checked every cycle,
// plus hand-computed literal expectations at key points.
module tb_spike_event_logger;

  logic        clk;
  logic        rst_n;
  logic        ena;
  logic        spike_n1;
  logic        spike_n2;
  logic [5:0]  weight;
  logic        clear;
  logic        rd_en;
  logic [17:0] rd_data;
  logic        rd_valid;
  logic [3:0]  level;
  logic        full;
  logic [7:0]  drop_count;
  logic        overflow;

  spike_event_logger #(
    .DEPTH (8),
    .TSW   (10)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .spike_n1   (spike_n1),
    .spike_n2   (spike_n2),
    .weight     (weight),
    .clear      (clear),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .level      (level),
    .full       (full),
    .drop_count (drop_count),
    .overflow   (overflow)
  );

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_on = 0;

  // Reference model state
  logic [17:0] q[$];
  int          m_ts   = 0;
  int          m_drop = 0;
  bit          m_ovf  = 0;
  int          m_sz;
  bit          m_ev;
  bit          m_pop;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_ts   = 0;
      m_drop = 0;
      m_ovf  = 0;
    end else if (clear) begin
      q.delete();
      m_ts   = 0;
      m_drop = 0;
      m_ovf  = 0;
    end else begin
      m_sz  = q.size();
      m_ev  = ena && (spike_n1 || spike_n2);
      m_pop = rd_en && (m_sz > 0);
      if (m_pop) void'(q.pop_front());
      if (m_ev) begin
        if (m_sz < 8 || m_pop) begin
          q.push_back({spike_n1, spike_n2, 10'(m_ts), weight});
        end else begin
          m_ovf = 1;
          if (m_drop < 255) m_drop++;
        end
      end
      if (ena) m_ts = (m_ts + 1) % 1024;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("model rd_valid", 32'(rd_valid), 32'(q.size() != 0));
      chk("model level", 32'(level), 32'(q.size()));
      chk("model full", 32'(full), 32'(q.size() == 8));
      chk("model drop_count", 32'(drop_count), 32'(m_drop));
      chk("model overflow", 32'(overflow), 32'(m_ovf));
      chk("model rd_data", 32'(rd_data), (q.size() != 0) ? 32'(q[0]) : 32'd0);
    end
  end

  initial begin
    int exp_ts[8];
    exp_ts = '{1, 2, 3, 4, 5, 6, 7, 10};
    rst_n = 1'b0; ena = 1'b0; spike_n1 = 1'b0; spike_n2 = 1'b0;
    weight = '0; clear = 1'b0; rd_en = 1'b0;
    step(1);
    chk_on = 1;
    step(1);
    chk("reset level", 32'(level), 32'd0);
    chk("reset rd_data", 32'(rd_data), 32'd0);

    // Idle counting from ts=0, then a spike at ts=5
    rst_n = 1'b1; ena = 1'b1;
    step(5);
    chk("idle rd_valid", 32'(rd_valid), 32'd0);
    chk("idle drop_count", 32'(drop_count), 32'd0);
    chk("idle overflow", 32'(overflow), 32'd0);
    spike_n1 = 1'b1; weight = 6'd17;
    step(1);
    spike_n1 = 1'b0;
    chk("ts5 rd_valid", 32'(rd_valid), 32'd1);
    chk("ts5 rd_data", 32'(rd_data), 32'h20151);
    chk("ts5 level", 32'(level), 32'd1);
    rd_en = 1'b1;
    step(1);
    chk("pop level", 32'(level), 32'd0);
    step(1);  // rd_en on empty FIFO
    rd_en = 1'b0;

    // Both neurons in one cycle
    spike_n1 = 1'b1; spike_n2 = 1'b1; weight = 6'd3;
    step(1);
    spike_n1 = 1'b0; spike_n2 = 1'b0;
    chk("dual src bits", 32'(rd_data[17:16]), 32'd3);
    chk("dual level", 32'(level), 32'd1);
    rd_en = 1'b1;
    step(1);
    rd_en = 1'b0;

    // Spikes ignored while ena=0
    ena = 1'b0; spike_n1 = 1'b1;
    step(3);
    spike_n1 = 1'b0; ena = 1'b1;
    chk("ena0 level", 32'(level), 32'd0);

    // Overflow: 10 events, no reads
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    for (int i = 0; i < 10; i++) begin
      spike_n1 = 1'b1; weight = 6'(i);
      step(1);
    end
    spike_n1 = 1'b0;
    chk("ovf level", 32'(level), 32'd8);
    chk("ovf full", 32'(full), 32'd1);
    chk("ovf drop_count", 32'(drop_count), 32'd2);
    chk("ovf overflow", 32'(overflow), 32'd1);

    // Push and pop while full
    spike_n2 = 1'b1; weight = 6'd42; rd_en = 1'b1;
    step(1);
    spike_n2 = 1'b0;
    chk("fullpp level", 32'(level), 32'd8);
    chk("fullpp drop_count", 32'(drop_count), 32'd2);
    for (int k = 0; k < 8; k++) begin
      chk("order ts", 32'(rd_data[15:6]), 32'(exp_ts[k]));
      if (k == 7) begin
        chk("tail src bits", 32'(rd_data[17:16]), 32'd1);
        chk("tail weight", 32'(rd_data[5:0]), 32'd42);
      end
      step(1);
    end
    rd_en = 1'b0;
    chk("drained level", 32'(level), 32'd0);

    // Clear drops sticky state
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    chk("clear overflow", 32'(overflow), 32'd0);
    chk("clear drop_count", 32'(drop_count), 32'd0);

    // Drop counter saturation
    spike_n1 = 1'b1;
    step(270);
    spike_n1 = 1'b0;
    chk("sat drop_count", 32'(drop_count), 32'd255);

    // Timestamp wrap, then clear with 3 entries stored
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    step(1024);
    spike_n1 = 1'b1; weight = 6'd9;
    step(3);
    spike_n1 = 1'b0;
    chk("wrap ts", 32'(rd_data[15:6]), 32'd0);
    chk("wrap level", 32'(level), 32'd3);
    clear = 1'b1; spike_n2 = 1'b1; rd_en = 1'b1;
    step(1);
    clear = 1'b0; spike_n2 = 1'b0; rd_en = 1'b0;
    chk("clr3 level", 32'(level), 32'd0);
    chk("clr3 rd_valid", 32'(rd_valid), 32'd0);
    chk("clr3 overflow", 32'(overflow), 32'd0);

    // Reset mid-operation overrides clear and discards entries
    spike_n1 = 1'b1;
    step(4);
    spike_n1 = 1'b0;
    rst_n = 1'b0; clear = 1'b1; spike_n2 = 1'b1;
    step(1);
    rst_n = 1'b1; clear = 1'b0; spike_n2 = 1'b0;
    chk("rst level", 32'(level), 32'd0);
    chk("rst rd_data", 32'(rd_data), 32'd0);
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
